// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer.
//   seq_state_t   : sequencer FSM state, 2-bit encoding
//   LOCK_FILT_LEN : consecutive synchronized lock samples needed to qualify
//                   lock when RESET_SEQ_LOCK_FILTER_EN is defined
package reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RELEASE   = 2'd1,
    DONE      = 2'd2,
    FAULT     = 2'd3
  } seq_state_t;

  localparam int LOCK_FILT_LEN = 8;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit.
//   STAGES : number of flops in the chain (>= 2)
// Ports:
//   clk : destination clock
//   rst : asynchronous active-high reset, clears every flop
//   i_d : asynchronous input bit
//   o_q : synchronized output, STAGES cycles behind i_d
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: waits for the clock source to lock, then releases the
// per-stage resets one at a time, STAGE_DELAY cycles apart. Lock loss
// re-asserts every stage and restarts the sequence; failing to lock within
// LOCK_TIMEOUT cycles raises a sticky lock_fault.
// Optional feature: define RESET_SEQ_LOCK_FILTER_EN to require
// LOCK_FILT_LEN consecutive high lock samples before lock is qualified.
// Parameters:
//   STAGE_NUM    : number of sequenced reset outputs
//   STAGE_DELAY  : cycles between consecutive stage releases (>= 1)
//   LOCK_TIMEOUT : cycles allowed in WAIT_LOCK before a fault (>= 2)
// Ports:
//   clk           : system clock
//   rst           : asynchronous active-high reset
//   pll_locked    : asynchronous lock indicator
//   rst_stage_out : active-high stage resets, bit 0 released first
//   init_done     : high once every stage is released
//   lock_fault    : sticky lock-timeout flag
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int STAGE_NUM    = 3,
  parameter int STAGE_DELAY  = 16,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pll_locked,
  output logic [STAGE_NUM-1:0] rst_stage_out,
  output logic                 init_done,
  output logic                 lock_fault
);

  localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
  localparam int DW = $clog2(STAGE_DELAY) + 1;
  localparam int IW = $clog2(STAGE_NUM) + 1;

  seq_state_t           r_state;
  logic [TW-1:0]        r_tcnt;
  logic [DW-1:0]        r_dcnt;
  logic [IW-1:0]        r_idx;
  logic                 w_locked_s;
  logic                 w_lock_qual;
  logic [STAGE_NUM-1:0] w_clr_mask;

  bit_sync #(
    .STAGES(2)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .i_d (pll_locked),
    .o_q (w_locked_s)
  );

`ifdef RESET_SEQ_LOCK_FILTER_EN
  localparam int FW = $clog2(LOCK_FILT_LEN) + 1;
  logic [FW-1:0] r_filt;

  // Counts consecutive high samples, saturating at LOCK_FILT_LEN-1; the
  // sample that finds the count saturated is the LOCK_FILT_LEN-th high one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt <= '0;
    end else if (!w_locked_s) begin
      r_filt <= '0;
    end else if (r_filt != FW'(LOCK_FILT_LEN - 1)) begin
      r_filt <= r_filt + 1'b1;
    end
  end

  assign w_lock_qual = w_locked_s && (r_filt == FW'(LOCK_FILT_LEN - 1));
`else
  assign w_lock_qual = w_locked_s;
`endif

  // Mask form avoids indexing the output with a counter wider than needed.
  assign w_clr_mask = ~(STAGE_NUM'(1) << r_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= WAIT_LOCK;
      rst_stage_out <= '1;
      init_done     <= 1'b0;
      lock_fault    <= 1'b0;
      r_tcnt        <= '0;
      r_dcnt        <= '0;
      r_idx         <= '0;
    end else begin
      case (r_state)
        WAIT_LOCK: begin
          rst_stage_out <= '1;
          init_done     <= 1'b0;
          if (w_lock_qual) begin
            r_state <= RELEASE;
            r_dcnt  <= '0;
            r_idx   <= '0;
            r_tcnt  <= '0;
          end else if (r_tcnt == TW'(LOCK_TIMEOUT - 1)) begin
            r_state    <= FAULT;
            lock_fault <= 1'b1;
            r_tcnt     <= '0;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end

        RELEASE: begin
          // Lock loss is checked first so it overrides a same-edge release.
          if (!w_locked_s) begin
            r_state       <= WAIT_LOCK;
            rst_stage_out <= '1;
            init_done     <= 1'b0;
            r_tcnt        <= '0;
            r_dcnt        <= '0;
            r_idx         <= '0;
          end else if (r_idx == IW'(STAGE_NUM)) begin
            r_state   <= DONE;
            init_done <= 1'b1;
          end else if (r_dcnt == DW'(STAGE_DELAY - 1)) begin
            rst_stage_out <= rst_stage_out & w_clr_mask;
            r_idx         <= r_idx + 1'b1;
            r_dcnt        <= '0;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end

        DONE: begin
          if (!w_locked_s) begin
            r_state       <= WAIT_LOCK;
            rst_stage_out <= '1;
            init_done     <= 1'b0;
            r_tcnt        <= '0;
            r_dcnt        <= '0;
            r_idx         <= '0;
          end
        end

        FAULT: begin
          rst_stage_out <= '1;
          init_done     <= 1'b0;
          if (w_locked_s) begin
            r_state <= WAIT_LOCK;
            r_tcnt  <= '0;
          end
        end

        default: begin
          r_state       <= WAIT_LOCK;
          rst_stage_out <= '1;
          init_done     <= 1'b0;
          r_tcnt        <= '0;
          r_dcnt        <= '0;
          r_idx         <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with STAGE_NUM=3, STAGE_DELAY=4,
// LOCK_TIMEOUT=16. Observed word is {rst_stage_out, init_done, lock_fault}.
// Edge numbers in comments count rising edges after rst deassertion.
module tb_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       pll_locked;
  logic [2:0] rst_stage_out;
  logic       init_done;
  logic       lock_fault;

  int checks   = 0;
  int failures = 0;

  reset_sequencer #(
    .STAGE_NUM   (3),
    .STAGE_DELAY (4),
    .LOCK_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .rst_stage_out(rst_stage_out),
    .init_done    (init_done),
    .lock_fault   (lock_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pll;
    int         ncyc;
    logic [2:0] st;
    logic       done;
    logic       fault;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [4:0] obs();
    return {rst_stage_out, init_done, lock_fault};
  endfunction

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got stages/done/fault=%b required=%b", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench at posedge+1 with rst just deasserted (edge count 0).
  task automatic do_reset();
    rst        = 1'b1;
    pll_locked = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    pll_locked = 1'b0;
    #2 rst = 1'b1;
    #1 chk("reset_state", obs(), 5'b111_0_0);

    // Lock constant high: RELEASE entered at edge 3, stages drop at 7/11/15,
    // init_done at 16; lock dropped after edge 21 is seen at edge 24.
    vecs[0]  = '{1'b1, 6, 3'b111, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1, 3'b110, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 3, 3'b110, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1, 3'b100, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 3, 3'b100, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1, 3'b000, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1, 3'b000, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 5, 3'b000, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 2, 3'b000, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1, 3'b111, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 6, 3'b111, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1, 3'b110, 1'b0, 1'b0};

    step(1);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      pll_locked = vecs[i].pll;
      step(vecs[i].ncyc);
      chk($sformatf("vec%0d", i), obs(), {vecs[i].st, vecs[i].done, vecs[i].fault});
    end

    // Lock timeout: fault at edge 16, then relock after edge 20 gives
    // FAULT->WAIT at 23, RELEASE at 24, stage0 at 28, done at 37.
    do_reset();
    step(15);
    chk("timeout_pre", obs(), 5'b111_0_0);
    step(1);
    chk("timeout_fault", obs(), 5'b111_0_1);
    step(4);
    chk("fault_hold", obs(), 5'b111_0_1);
    pll_locked = 1'b1;
    step(7);
    chk("fault_relock_pre", obs(), 5'b111_0_1);
    step(1);
    chk("fault_relock_st0", obs(), 5'b110_0_1);
    step(9);
    chk("fault_relock_done", obs(), 5'b000_1_1);

    // Asynchronous reset from DONE, away from any clock edge.
    #2 rst = 1'b1;
    #1 chk("async_rst_done", obs(), 5'b111_0_0);
    step(1);
    rst = 1'b0;
    chk("async_rst_hold", obs(), 5'b111_0_0);

    // Lock dropped after edge 9 (RELEASE+6): seen at edge 12, stage1 still
    // drops at edge 11. Relock gives RELEASE at 15, stage0 at 19.
    pll_locked = 1'b1;
    step(9);
    chk("drop_pre", obs(), 5'b110_0_0);
    pll_locked = 1'b0;
    step(2);
    chk("drop_st1", obs(), 5'b100_0_0);
    step(1);
    chk("drop_restart", obs(), 5'b111_0_0);
    pll_locked = 1'b1;
    step(6);
    chk("drop_relock_pre", obs(), 5'b111_0_0);
    step(1);
    chk("drop_relock_st0", obs(), 5'b110_0_0);

    // Lock loss first seen on the stage-0 release edge (edge 7).
    do_reset();
    pll_locked = 1'b1;
    step(4);
    pll_locked = 1'b0;
    step(3);
    chk("loss_wins_edge", obs(), 5'b111_0_0);
    step(1);
    chk("loss_wins_after", obs(), 5'b111_0_0);

`ifdef RESET_SEQ_LOCK_FILTER_EN
    // High 5, low 1, high on: FSM samples high at 3..7, low at 8, high from 9;
    // the 8th consecutive high sample is edge 16, stage0 released at 20.
    do_reset();
    pll_locked = 1'b1;
    step(5);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(13);
    chk("filter_pre", obs(), 5'b111_0_0);
    step(1);
    chk("filter_st0", obs(), 5'b110_0_0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
